// File: rtl/dds_reg_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dds_reg_seq_pkg
// Description : Shared definitions for the DDS register sequencer: FSM state
//               encoding, instruction-byte field positions, payload limits and
//               small helper functions.
//               Optional feature macro: DDS_IO_UPDATE_EN (adds the UPDATE state).
// Revision    : 1.0 - initial release
// ============================================================================
package dds_reg_seq_pkg;

  localparam int c_MAX_LEN  = 8;   // maximum payload bytes per command
  localparam int c_RW_BIT   = 7;   // instruction byte: read/write flag
  localparam int c_ADDR_MSB = 4;   // instruction byte: address field
  localparam int c_ADDR_LSB = 0;
  localparam int c_ADDR_W   = 5;
  localparam int c_LEN_W    = 4;
  localparam int c_DATA_W   = 64;
  localparam int c_BYTE_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_GAP    = 3'd4,
`ifdef DDS_IO_UPDATE_EN
    ST_UPDATE = 3'd5,
`endif
    ST_DONE   = 3'd6
  } state_t;

  // Instruction byte {rw, 2'b00, addr}
  function automatic logic [c_BYTE_W-1:0] instr_byte(input logic rw,
                                                     input logic [c_ADDR_W-1:0] addr);
    logic [c_BYTE_W-1:0] b;
    b = '0;
    b[c_RW_BIT] = rw;
    b[c_ADDR_MSB:c_ADDR_LSB] = addr;
    return b;
  endfunction

  // Requested lengths above the payload limit are truncated to the limit
  function automatic logic [c_LEN_W-1:0] clamp_len(input logic [c_LEN_W-1:0] len);
    return (len > c_LEN_W'(c_MAX_LEN)) ? c_LEN_W'(c_MAX_LEN) : len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dds_reg_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : dds_reg_seq_if
// Description : Command, byte-engine and read-result signals of the DDS
//               register sequencer.
//               slave  : sequencer side (cmd_*, spi_cs, spi_out in;
//                        cmd_ready, spi_in, spi_start, rd_*, busy out)
//               master : requester / byte-engine side (mirror image)
// Revision    : 1.0 - initial release
// ============================================================================
interface dds_reg_seq_if;
  import dds_reg_seq_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_rw;
  logic [c_ADDR_W-1:0]   cmd_addr;
  logic [c_LEN_W-1:0]    cmd_len;
  logic [c_DATA_W-1:0]   cmd_data;
  logic [c_BYTE_W-1:0]   spi_in;
  logic                  spi_start;
  logic                  spi_cs;
  logic [c_BYTE_W-1:0]   spi_out;
  logic [c_DATA_W-1:0]   rd_data;
  logic                  rd_valid;
  logic                  busy;

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_len, cmd_data, spi_cs, spi_out,
    output cmd_ready, spi_in, spi_start, rd_data, rd_valid, busy
  );

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_len, cmd_data, spi_cs, spi_out,
    input  cmd_ready, spi_in, spi_start, rd_data, rd_valid, busy
  );

endinterface
`default_nettype wire

// File: rtl/dds_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : dds_edge_det
// Description : Registers the engine chip-select and flags its 0->1 edge.
//               clk, rst : clock, synchronous active-high reset
//               i_sig    : monitored level
//               o_rise   : high for the one cycle in which i_sig is first seen
//                          high after having been low
// Revision    : 1.0 - initial release
// ============================================================================
module dds_edge_det (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_sig,
  output logic      o_rise
);

  logic r_prev;

  // Reset to 1 so a chip-select idling high does not look like an edge.
  always_ff @(posedge clk) begin
    if (rst) r_prev <= 1'b1;
    else     r_prev <= i_sig;
  end

  assign o_rise = i_sig & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/dds_reg_seq.sv
`default_nettype none
// ============================================================================
// Module      : dds_reg_seq
// Description : Turns one register command into an instruction byte plus up to
//               eight payload bytes for a byte-level SPI engine, collects read
//               bytes and reports completion.
//               clk, rst  : clock, synchronous active-high reset
//               bus       : dds_reg_seq_if.slave (command, engine, read result)
//               io_update : DDS update pulse after writes (DDS_IO_UPDATE_EN only)
//               Optional feature macro: DDS_IO_UPDATE_EN
// Revision    : 1.0 - initial release
// ============================================================================
module dds_reg_seq
  import dds_reg_seq_pkg::*;
#(
  parameter int unsigned START_HOLD = 5,   // spi_start cycles per byte (>=1)
  parameter int unsigned GAP_CYCLES = 2,   // idle cycles after byte done (>=1)
  parameter int unsigned UPD_CYCLES = 4    // io_update width (>=1)
) (
  input  wire logic     clk,
  input  wire logic     rst,
  dds_reg_seq_if.slave  bus
`ifdef DDS_IO_UPDATE_EN
  ,
  output logic          io_update
`endif
);

  localparam logic [15:0] c_START_LAST = 16'(START_HOLD - 1);
  localparam logic [15:0] c_GAP_LAST   = 16'(GAP_CYCLES - 1);
`ifdef DDS_IO_UPDATE_EN
  localparam logic [15:0] c_UPD_LAST   = 16'(UPD_CYCLES - 1);
`endif

  state_t                r_state;
  state_t                w_state_nxt;
  logic [15:0]           r_cnt;        // cycles spent in the current state
  logic                  r_rw;
  logic [c_ADDR_W-1:0]   r_addr;
  logic [c_LEN_W-1:0]    r_len;
  logic [c_LEN_W-1:0]    r_idx;        // 0 = instruction, 1..len = payload
  logic [c_DATA_W-1:0]   r_data;       // payload, left-aligned, shifted out MSB first
  logic [c_BYTE_W-1:0]   r_spi_in;
  logic [c_DATA_W-1:0]   r_rd_data;
  logic                  w_cs_rise;
  logic                  w_accept;
  logic [c_LEN_W-1:0]    w_len;
  logic [c_LEN_W-1:0]    w_pad;
  logic [6:0]            w_shift;

  dds_edge_det u_cs_edge (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (bus.spi_cs),
    .o_rise (w_cs_rise)
  );

  assign w_accept = (r_state == ST_IDLE) && bus.cmd_valid;
  assign w_len    = clamp_len(bus.cmd_len);
  // Left-align the right-aligned payload so the first payload byte is [63:56].
  assign w_pad    = c_LEN_W'(c_MAX_LEN) - w_len;
  assign w_shift  = {w_pad, 3'b000};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (bus.cmd_valid) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_START;
      ST_START: if (r_cnt == c_START_LAST) w_state_nxt = ST_WAIT;
      ST_WAIT:  if (w_cs_rise) w_state_nxt = ST_GAP;
      ST_GAP: begin
        if (r_cnt == c_GAP_LAST) begin
          if (r_idx != r_len) begin
            w_state_nxt = ST_LOAD;
          end else if (r_rw) begin
            w_state_nxt = ST_DONE;
          end else begin
`ifdef DDS_IO_UPDATE_EN
            w_state_nxt = ST_UPDATE;
`else
            w_state_nxt = ST_DONE;
`endif
          end
        end
      end
`ifdef DDS_IO_UPDATE_EN
      ST_UPDATE: if (r_cnt == c_UPD_LAST) w_state_nxt = ST_DONE;
`endif
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_rw      <= 1'b0;
      r_addr    <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_data    <= '0;
      r_spi_in  <= '0;
      r_rd_data <= '0;
    end else begin
      // Restart the dwell counter on every state change.
      if (r_state != w_state_nxt) r_cnt <= '0;
      else                        r_cnt <= r_cnt + 16'd1;

      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rw   <= bus.cmd_rw;
            r_addr <= bus.cmd_addr;
            r_len  <= w_len;
            r_data <= bus.cmd_data << w_shift;
            r_idx  <= '0;
            // Read results persist across writes; only a new read clears them.
            if (bus.cmd_rw) r_rd_data <= '0;
          end
        end
        ST_LOAD: begin
          if (r_idx == '0) begin
            r_spi_in <= instr_byte(r_rw, r_addr);
          end else begin
            r_spi_in <= r_data[c_DATA_W-1 -: c_BYTE_W];
            r_data   <= r_data << c_BYTE_W;
          end
        end
        ST_WAIT: begin
          if (w_cs_rise && r_rw && (r_idx != '0))
            r_rd_data <= {r_rd_data[c_DATA_W-c_BYTE_W-1:0], bus.spi_out};
        end
        ST_GAP: begin
          if (w_state_nxt == ST_LOAD) r_idx <= r_idx + c_LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // ----------------------------------------------------------- outputs
  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.spi_start = (r_state == ST_START);
  assign bus.spi_in    = r_spi_in;
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid  = (r_state == ST_DONE) && r_rw;
`ifdef DDS_IO_UPDATE_EN
  assign io_update     = (r_state == ST_UPDATE);
`endif

endmodule
`default_nettype wire
